// File: rtl/stream_proc_mc_if.sv
// Valid/ready bundle for stream_proc_mc: NUM_CH merged input streams plus one tagged output stream.
interface stream_proc_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_proc_mc.sv
// Multi-channel stream processor: round-robin merge into a FIFO, per-beat transform,
// channel-tagged registered output, under a RUN/DRAIN/DONE control FSM.
module stream_proc_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [DATA_WIDTH-1:0]  operand,
    stream_proc_mc_if.slave        bus,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int EW   = CH_W + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] operand_q;

    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       grant;
    logic                  any_valid;
    logic [NUM_CH-1:0]     in_ready_c;

    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic                  empty, full, wr_en, rd_en;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         wr_entry, rd_entry;
    logic [CH_W-1:0]       rd_ch;
    logic [DATA_WIDTH-1:0] rd_data, xf_data;
    logic [DATA_WIDTH:0]   sum;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            operand_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && en) begin
                mode_q    <= mode;
                operand_q <= operand;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: if (empty && !out_valid_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        grant      = '0;
        any_valid  = 1'b0;
        in_ready_c = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_valid && bus.in_valid[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                any_valid = 1'b1;
                grant     = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
        // Full is judged on registered pointers: a same-cycle read does not open a slot.
        if (state_q == S_RUN && !full && any_valid) in_ready_c[grant] = 1'b1;
        if (|in_ready_c) rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end

    assign wr_en        = |in_ready_c;
    assign wr_entry     = {grant, bus.in_data[grant*DATA_WIDTH +: DATA_WIDTH]};
    assign bus.in_ready = in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    // ---------------- FIFO ----------------
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rd_en = !empty && (!out_valid_q || bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; resetting the pointers is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_ch    = rd_entry[EW-1 -: CH_W];
    assign rd_data  = rd_entry[DATA_WIDTH-1:0];

    // ---------------- transform ----------------
    always_comb begin
        sum     = {1'b0, rd_data} + {1'b0, operand_q};
        xf_data = rd_data;
        unique case (mode_q)
            2'b00: xf_data = rd_data;
            2'b01: xf_data = sum[DATA_WIDTH-1:0];
            2'b10: xf_data = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
            2'b11: xf_data = rd_data ^ operand_q;
            default: xf_data = rd_data;
        endcase
    end

    // ---------------- output register ----------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = xf_data;
            out_ch_d    = rd_ch;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_proc_mc.sv
// Self-checking bench for stream_proc_mc: scoreboard of expected {ch,data} beats plus
// per-scenario directed checks.
module tb_stream_proc_mc;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int NCH   = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] operand;
    logic          busy;
    logic          done;
    logic [3:0]    level;

    stream_proc_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    stream_proc_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .operand (operand),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .level   (level)
    );

    int            errors = 0;
    int            checks = 0;
    logic [33:0]   sb [$];
    int            acc_ch [$];
    int            out_count = 0;
    logic [DW-1:0] last_out = '0;
    logic [1:0]    exp_mode = '0;
    logic [DW-1:0] exp_op = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] op,
                                            input logic [DW-1:0] d);
        logic [DW:0] s;
        s = {1'b0, d} + {1'b0, op};
        case (m)
            2'b00:   return d;
            2'b01:   return d + op;
            2'b10:   return s[DW] ? 32'hFFFF_FFFF : s[DW-1:0];
            default: return d ^ op;
        endcase
    endfunction

    // Handshakes are sampled mid-cycle; they describe the transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [33:0] exp;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got ch=%0d data=%h, expected no beat",
                             bus.out_ch, bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.out_ch, bus.out_data} !== exp) begin
                        errors++;
                        $display("FAIL sb_beat: got ch=%0d data=%h, expected ch=%0d data=%h",
                                 bus.out_ch, bus.out_data, exp[33:32], exp[31:0]);
                    end
                end
                last_out = bus.out_data;
                out_count++;
            end
            checks++;
            if ($countones(bus.in_ready) > 1) begin
                errors++;
                $display("FAIL in_ready_onehot: got %b, expected one-hot or zero", bus.in_ready);
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i]) begin
                    sb.push_back({i[1:0], xform(exp_mode, exp_op, bus.in_data[i*DW +: DW])});
                    acc_ch.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        en           = 1'b0;
        bus.in_valid = '0;
        tick();
        tick();
        sb.delete();
        acc_ch.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_run(input logic [1:0] m, input logic [DW-1:0] op);
        en       = 1'b1;
        mode     = m;
        operand  = op;
        exp_mode = m;
        exp_op   = op;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL run_busy: got %b, expected 1", busy);
        end
    endtask

    task automatic send_beat(input int ch, input logic [DW-1:0] d);
        int waited = 0;
        bus.in_data[ch*DW +: DW] = d;
        bus.in_valid             = '0;
        bus.in_valid[ch]         = 1'b1;
        #1;
        while (!bus.in_ready[ch] && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!bus.in_ready[ch]) begin
            errors++;
            $display("FAIL send_timeout: ch=%0d in_ready=%b, expected grant", ch, bus.in_ready);
        end
        tick();
        bus.in_valid = '0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((sb.size() != 0 || bus.out_valid) && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic stop_and_wait();
        bit found = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: got done=%b, expected a pulse", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: got %b, expected 0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b busy=%b, expected 0 0", done, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_pending: got %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            en            = 1'($urandom);
            mode          = 2'($urandom);
            operand       = $urandom;
            bus.in_valid  = 4'($urandom);
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_ch, busy, done, bus.in_ready, level} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got ov=%b od=%h ch=%0d busy=%b done=%b rdy=%b lvl=%0d, expected all 0",
                         bus.out_valid, bus.out_data, bus.out_ch, busy, done, bus.in_ready, level);
            end
        end
        en            = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b in_ready=%b, expected 0 0000", busy, bus.in_ready);
        end
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        start_run(2'b01, 32'h1);
        bus.in_data[2*DW +: DW] = 32'h10;
        bus.in_valid            = 4'b0100;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 0100", bus.in_ready);
        end
        tick();
        bus.in_valid = '0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got out_valid=%b, expected 0", bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 || bus.out_ch !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h ch=%0d, expected 1 00000011 2",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        wait_drain();
        stop_and_wait();
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] acc;
        int             max_level = 0;
        bit             order_ok  = 1'b1;
        apply_reset();
        bus.out_ready = 1'b1;
        start_run(2'b00, 32'h0);
        for (int i = 0; i < NCH; i++) bus.in_data[i*DW +: DW] = 32'(i << 8);
        bus.in_valid = 4'b1111;
        #1;
        for (int k = 0; k < 16; k++) begin
            acc = bus.in_valid & bus.in_ready;
            tick();
            for (int i = 0; i < NCH; i++)
                if (acc[i]) bus.in_data[i*DW +: DW] = bus.in_data[i*DW +: DW] + 1;
            if (int'(level) > max_level) max_level = int'(level);
        end
        bus.in_valid = '0;
        checks++;
        if (acc_ch.size() != 16) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, expected 16", acc_ch.size());
        end
        for (int k = 0; k < acc_ch.size(); k++)
            if (acc_ch[k] != k % NCH) order_ok = 1'b0;
        checks++;
        if (!order_ok) begin
            errors++;
            $display("FAIL rr_order: got first grants %0d %0d %0d %0d, expected 0 1 2 3 ...",
                     acc_ch[0], acc_ch[1], acc_ch[2], acc_ch[3]);
        end
        checks++;
        if (max_level > 2) begin
            errors++;
            $display("FAIL rr_level: got max %0d, expected <= 2", max_level);
        end
        wait_drain();
        stop_and_wait();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d = '0;
        bit            acc;
        bit            stable = 1'b1;
        int            base;
        int            gaps = 0;
        apply_reset();
        start_run(2'b00, 32'h0);
        bus.out_ready        = 1'b0;
        bus.in_data[0 +: DW] = d;
        bus.in_valid         = 4'b0001;
        #1;
        for (int k = 0; k < 15; k++) begin
            acc = bus.in_valid[0] & bus.in_ready[0];
            tick();
            if (acc) begin
                d++;
                bus.in_data[0 +: DW] = d;
            end
        end
        checks++;
        if (bus.in_ready !== 4'b0000 || level !== 4'd8 || d !== 32'd9) begin
            errors++;
            $display("FAIL full_state: got in_ready=%b level=%0d accepted=%0d, expected 0000 8 9",
                     bus.in_ready, level, d);
        end
        for (int k = 0; k < 3; k++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) stable = 1'b0;
            tick();
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h, expected 1 00000000 held", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        base          = out_count;
        for (int k = 0; k < 40; k++) begin
            if (out_count - base >= 10) break;
            if (!bus.out_valid) gaps++;
            acc = bus.in_valid[0] & bus.in_ready[0];
            tick();
            if (acc) begin
                if (d == 32'd9) bus.in_valid = '0;
                else begin
                    d++;
                    bus.in_data[0 +: DW] = d;
                end
            end
        end
        checks++;
        if (out_count - base != 10 || gaps != 0) begin
            errors++;
            $display("FAIL bp_release: got %0d beats with %0d gaps, expected 10 with 0",
                     out_count - base, gaps);
        end
        wait_drain();
        stop_and_wait();
    endtask

    task automatic test_sat_xor();
        bus.out_ready = 1'b1;
        start_run(2'b10, 32'h10);
        send_beat(1, 32'hFFFF_FFF8);
        wait_drain();
        checks++;
        if (last_out !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_clip: got %h, expected ffffffff", last_out);
        end
        send_beat(2, 32'hFFFF_FFEF);
        wait_drain();
        checks++;
        if (last_out !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_edge: got %h, expected ffffffff", last_out);
        end
        send_beat(3, 32'h5);
        wait_drain();
        checks++;
        if (last_out !== 32'h15) begin
            errors++;
            $display("FAIL sat_small: got %h, expected 00000015", last_out);
        end
        stop_and_wait();
        start_run(2'b11, 32'hFFFF_0000);
        send_beat(0, 32'h1234_5678);
        wait_drain();
        checks++;
        if (last_out !== 32'hEDCB_5678) begin
            errors++;
            $display("FAIL xor_out: got %h, expected edcb5678", last_out);
        end
        stop_and_wait();
        start_run(2'b01, 32'h10);
        send_beat(1, 32'hFFFF_FFF8);
        wait_drain();
        checks++;
        if (last_out !== 32'h8) begin
            errors++;
            $display("FAIL wrap_out: got %h, expected 00000008", last_out);
        end
        stop_and_wait();
    endtask

    task automatic test_midrun();
        bit done_seen = 1'b0;
        bus.out_ready = 1'b1;
        start_run(2'b01, 32'h5);
        mode    = 2'b11;
        operand = 32'h0;
        send_beat(0, 32'h20);
        wait_drain();
        checks++;
        if (last_out !== 32'h25) begin
            errors++;
            $display("FAIL cfg_latched: got %h, expected 00000025", last_out);
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send_beat(k % NCH, 32'(k));
        checks++;
        if (level !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d, expected 5", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got level=%0d ov=%b busy=%b rdy=%b, expected 0 0 0 0000",
                     level, bus.out_valid, busy, bus.in_ready);
        end
        sb.delete();
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (done_seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done_seen=%b busy=%b, expected 0 0", done_seen, busy);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        mode          = '0;
        operand       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sat_xor();
        test_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
